// File: rtl/drum_mac_pkg.sv
// Shared types and constants for the DRUM6 MAC accumulator.
// State encoding and default widths live here so that every file agrees on them.
package drum_mac_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    localparam int ACC_W_DEFAULT = 40;
    localparam int COUNT_W       = 16;

endpackage

// File: rtl/DRUM6_16_u.sv
// DRUM6 16-bit unsigned approximate multiplier.
// Each operand keeps its top 6 bits from the leading one, with the LSB forced to 1.
module DRUM6_16_u (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] r
);

    // Returns {shift[3:0], mantissa[5:0]}.
    // Operands below 64 pass through exactly.
    function automatic logic [9:0] trunc6(input logic [15:0] v);
        logic [9:0] res;
        res = {4'd0, v[5:0]};
        for (int k = 6; k < 16; k++) begin
            if (v[k]) res = {4'(k - 5), v[k -: 6] | 6'd1};
        end
        return res;
    endfunction

    logic [9:0]  ta;
    logic [9:0]  tb;
    logic [11:0] pm;
    logic [4:0]  sh;

    // Multiply the truncated mantissas, then shift the product back into place.
    always_comb begin
        ta = trunc6(a);
        tb = trunc6(b);
        pm = {6'd0, ta[5:0]} * {6'd0, tb[5:0]};
        sh = {1'b0, ta[9:6]} + {1'b0, tb[9:6]};
        r  = {20'd0, pm} << sh;
    end

endmodule

// File: rtl/drum_acc_sat.sv
// Combinational accumulator adder with an overflow policy.
// SAT=1 clamps to all-ones on carry out, and SAT=0 wraps modulo 2^W.
module drum_acc_sat #(
    parameter int W   = 40,
    parameter bit SAT = 1'b1
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] p,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    // Widen by one bit so the carry out is the overflow flag.
    always_comb begin
        full = {1'b0, acc} + {1'b0, p};
        ovf  = full[W];
        sum  = (SAT && full[W]) ? {W{1'b1}} : full[W-1:0];
    end

endmodule

// File: rtl/drum6_mac_accumulator.sv
// Streaming approximate MAC: the product is registered in S1 and accumulated in S2.
// The group result is held on a valid/ready output until it is taken.
module drum6_mac_accumulator
    import drum_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter bit SAT   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_a,
    input  logic [15:0]        in_b,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_ovf
);

    state_t               state;
    logic                 accept;
    logic [31:0]          prod;
    logic                 s1_valid;
    logic                 s1_last;
    logic [ACC_W-1:0]     s1_p;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     sum;
    logic                 add_ovf;
    logic                 ovf;
    logic [COUNT_W-1:0]   count;
    logic [COUNT_W-1:0]   count_nxt;

    assign in_ready  = (state == ACCUM);
    assign accept    = in_valid & in_ready;
    assign count_nxt = (count == {COUNT_W{1'b1}}) ? count : count + 1'b1;

    DRUM6_16_u u_mul (
        .a (in_a),
        .b (in_b),
        .r (prod)
    );

    drum_acc_sat #(
        .W   (ACC_W),
        .SAT (SAT)
    ) u_add (
        .acc (acc),
        .p   (s1_p),
        .sum (sum),
        .ovf (add_ovf)
    );

    // S1: capture the product and last flag of each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_p     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_p    <= ACC_W'(prod);
                s1_last <= in_last;
            end
        end
    end

    // S2 accumulate plus group control: drain the last beat, then hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (s1_valid) begin
                acc   <= sum;
                count <= count_nxt;
                ovf   <= ovf | add_ovf;
            end
            unique case (state)
                ACCUM: begin
                    if (accept && in_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (s1_valid && s1_last) begin
                        out_acc   <= sum;
                        out_count <= count_nxt;
                        out_ovf   <= ovf | add_ovf;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                        ovf       <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_drum6_mac_accumulator.sv
// Directed bench for drum6_mac_accumulator.
// Three instances share one stimulus: 40-bit default, 33-bit saturating, 33-bit wrapping.
module tb_drum6_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy40, rdy33s, rdy33w;
    logic        vld40, vld33s, vld33w;
    logic [39:0] acc40;
    logic [32:0] acc33s, acc33w;
    logic [15:0] cnt40, cnt33s, cnt33w;
    logic        ovf40, ovf33s, ovf33w;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    drum6_mac_accumulator u40 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy40),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(vld40), .out_ready(out_ready),
        .out_acc(acc40), .out_count(cnt40), .out_ovf(ovf40)
    );

    drum6_mac_accumulator #(.ACC_W(33), .SAT(1'b1)) u33s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy33s),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(vld33s), .out_ready(out_ready),
        .out_acc(acc33s), .out_count(cnt33s), .out_ovf(ovf33s)
    );

    drum6_mac_accumulator #(.ACC_W(33), .SAT(1'b0)) u33w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy33w),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(vld33w), .out_ready(out_ready),
        .out_acc(acc33w), .out_count(cnt33w), .out_ovf(ovf33w)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // After the last beat: still low one cycle later, high the next.
    task automatic expect_result(input string tag);
        chk({tag, "_lat1"}, 64'(vld40), 64'd0);
        step();
        chk({tag, "_valid"}, 64'(vld40), 64'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("take_valid_low", 64'(vld40), 64'd0);
        chk("take_ready_high", 64'(rdy40), 64'd1);
    endtask

    initial begin
        #12;
        chk("rst_valid", 64'(vld40), 64'd0);
        chk("rst_acc", 64'(acc40), 64'd0);
        chk("rst_count", 64'(cnt40), 64'd0);
        chk("rst_ovf", 64'(ovf40), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_ready", 64'(rdy40), 64'd1);

        // 15 + 63 + 100
        send(16'd3, 16'd5, 1'b0);
        send(16'd7, 16'd9, 1'b0);
        send(16'd10, 16'd10, 1'b1);
        chk("g1_ready_low", 64'(rdy40), 64'd0);
        expect_result("g1");
        chk("g1_acc", 64'(acc40), 64'd178);
        chk("g1_count", 64'(cnt40), 64'd3);
        chk("g1_ovf", 64'(ovf40), 64'd0);
        take();

        // 1000 -> 63<<4 each, 3969<<8
        send(16'd1000, 16'd1000, 1'b1);
        expect_result("g2");
        chk("g2_acc", 64'(acc40), 64'd1016064);
        chk("g2_count", 64'(cnt40), 64'd1);
        take();

        // 0xFFFF^2 approx = 3969<<20 = 0xF810_0000, three times
        send(16'hFFFF, 16'hFFFF, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        expect_result("g3");
        chk("g3_acc40", 64'(acc40), 64'h2_E830_0000);
        chk("g3_ovf40", 64'(ovf40), 64'd0);
        chk("g3_acc33s", 64'(acc33s), 64'h1_FFFF_FFFF);
        chk("g3_ovf33s", 64'(ovf33s), 64'd1);
        chk("g3_acc33w", 64'(acc33w), 64'h0_E830_0000);
        chk("g3_ovf33w", 64'(ovf33w), 64'd1);
        chk("g3_count", 64'(cnt33s), 64'd3);

        // Stall the output with a beat waiting upstream.
        in_valid = 1'b1;
        in_a     = 16'd1;
        in_b     = 16'd1;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", 64'(vld40), 64'd1);
            chk("hold_acc", 64'(acc33s), 64'h1_FFFF_FFFF);
            chk("hold_ready", 64'(rdy40), 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("rel_ready", 64'(rdy40), 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("g4");
        chk("g4_acc33s", 64'(acc33s), 64'd1);
        chk("g4_ovf33s", 64'(ovf33s), 64'd0);
        chk("g4_count", 64'(cnt40), 64'd1);
        take();

        // Reset mid-group discards the partial sum.
        send(16'd4, 16'd4, 1'b0);
        send(16'd5, 16'd5, 1'b0);
        rst_n = 1'b0;
        #3;
        chk("mid_rst_valid", 64'(vld40), 64'd0);
        rst_n = 1'b1;
        step();
        chk("mid_rst_ready", 64'(rdy40), 64'd1);
        send(16'd2, 16'd3, 1'b1);
        expect_result("g5");
        chk("g5_acc", 64'(acc40), 64'd6);
        chk("g5_count", 64'(cnt40), 64'd1);
        take();

        // Zero operands still count.
        send(16'd0, 16'd7, 1'b0);
        send(16'd0, 16'd0, 1'b1);
        expect_result("g6");
        chk("g6_acc", 64'(acc40), 64'd0);
        chk("g6_count", 64'(cnt40), 64'd2);
        take();

        // 63*63 exact; 64 -> 33<<1 so 66*66 = 4356
        send(16'd63, 16'd63, 1'b0);
        send(16'd64, 16'd64, 1'b1);
        expect_result("g7");
        chk("g7_acc", 64'(acc40), 64'd8325);
        chk("g7_count", 64'(cnt40), 64'd2);
        take();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
